// File: rtl/product_acc_pkg.sv
// Shared types and default widths for the product accumulator datapath.
// The helper is the saturating add at default tile widths; sat_adder is its width-generic form.
package product_acc_pkg;

  localparam int IN_W  = 8;
  localparam int ACC_W = 12;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Returns {overflow, clamped sum}.
  function automatic logic [ACC_W:0] satadd(input logic [ACC_W-1:0] acc,
                                            input logic [IN_W-1:0]  d);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + {{(ACC_W+1-IN_W){1'b0}}, d};
    return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
  endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Combinational saturating adder: accumulator plus zero-extended product, clamped to all-ones.
module product_accumulator_sat_adder #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, i_acc} + {{(ACC_W+1-IN_W){1'b0}}, i_data};
  assign o_ovf  = w_full[ACC_W];
  assign o_sum  = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmed number of multiplier products into a saturating accumulator
// and hands the result out over a valid/ready handshake.
module product_accumulator #(
  parameter int IN_W  = product_acc_pkg::IN_W,
  parameter int ACC_W = product_acc_pkg::ACC_W,
  parameter int LEN_W = product_acc_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat
);

  import product_acc_pkg::*;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_sat;

  logic             w_beat;
  logic             w_start_ok;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;

  product_accumulator_sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .i_acc  (r_acc),
    .i_data (in_data),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  assign w_beat     = in_valid && (r_state == ACCUM);
  assign w_start_ok = start && (len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_len   <= len;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            if (w_ovf) r_sat <= 1'b1;
            if (r_cnt == r_len - 1'b1) r_state <= DONE;
          end
        end
        DONE: begin
          // A start coinciding with the handshake chains straight into the next run.
          if (out_ready) begin
            if (w_start_ok) begin
              r_len   <= len;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_sat   <= 1'b0;
              r_state <= ACCUM;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign sat       = r_sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default 12-bit instance plus an 8-bit
// accumulator instance sharing the same stimulus to exercise saturation.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, busy, sat;
  logic [11:0] out_sum;
  logic [3:0]  out_count;

  logic        in_ready8, out_valid8, busy8, sat8;
  logic [7:0]  out_sum8;
  logic [3:0]  out_count8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .sat       (sat)
  );

  product_accumulator #(.ACC_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .out_sum   (out_sum8),
    .out_count (out_count8),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .busy      (busy8),
    .sat       (sat8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [3:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_count", out_count, 0);
    chk("rst_sat",       sat,       0);
    rst = 1'b0;

    // reset in the middle of a run
    kick(4'd5);
    beat(8'd7);
    beat(8'd7);
    chk("mid_busy", busy,    1);
    chk("mid_sum",  out_sum, 14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy",  busy,      0);
    chk("mid_rst_sum",   out_sum,   0);
    chk("mid_rst_ready", in_ready,  0);
    chk("mid_rst_valid", out_valid, 0);

    kick(4'd1);
    beat(8'd9);
    chk("len1_valid", out_valid, 1);
    chk("len1_sum",   out_sum,   9);
    handshake();
    chk("len1_after_valid", out_valid, 0);

    // basic run 225+6+16
    kick(4'd3);
    beat(8'd225);
    beat(8'd6);
    chk("basic_early_valid", out_valid, 0);
    beat(8'd16);
    chk("basic_valid", out_valid, 1);
    chk("basic_sum",   out_sum,   247);
    chk("basic_count", out_count, 3);
    chk("basic_sat",   sat,       0);
    handshake();
    chk("basic_idle_busy", busy,    0);
    chk("basic_hold_sum",  out_sum, 247);

    // gaps and backpressure
    kick(4'd2);
    beat(8'd100);
    step(); step(); step();
    chk("gap_ready", in_ready,  1);
    chk("gap_count", out_count, 1);
    chk("gap_sum",   out_sum,   100);
    beat(8'd50);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'd77;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_sum",   out_sum,   150);
    end
    in_valid = 1'b0;
    chk("bp_count", out_count, 2);
    chk("bp_ready", in_ready,  0);
    handshake();
    chk("bp_after_valid", out_valid, 0);
    chk("bp_hold_sum",    out_sum,   150);

    // full-length run
    kick(4'd15);
    for (int i = 0; i < 15; i++) beat(8'd225);
    chk("full_valid", out_valid, 1);
    chk("full_sum",   out_sum,   3375);
    chk("full_count", out_count, 15);
    chk("full_sat",   sat,       0);
    handshake();

    // saturation on the 8-bit accumulator
    kick(4'd2);
    beat(8'd200);
    beat(8'd100);
    chk("sat8_valid", out_valid8, 1);
    chk("sat8_sum",   out_sum8,   255);
    chk("sat8_flag",  sat8,       1);
    chk("sat12_sum",  out_sum,    300);
    chk("sat12_flag", sat,        0);
    handshake();
    chk("sat8_sticky", sat8, 1);
    kick(4'd1);
    chk("sat8_clear", sat8, 0);
    beat(8'd5);
    chk("sat8_next_sum", out_sum8, 5);
    chk("sat8_next_flag", sat8,    0);
    handshake();

    // zero-length start is ignored
    kick(4'd0);
    chk("len0_busy",  busy,     0);
    chk("len0_ready", in_ready, 0);

    // back-to-back runs through the handshake cycle
    kick(4'd1);
    beat(8'd4);
    chk("b2b_first_sum", out_sum, 4);
    start = 1'b1; len = 4'd1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("b2b_ready", in_ready,  1);
    chk("b2b_valid", out_valid, 0);
    chk("b2b_busy",  busy,      1);
    beat(8'd11);
    chk("b2b_valid2", out_valid, 1);
    chk("b2b_sum2",   out_sum,   11);
    chk("b2b_count2", out_count, 1);
    handshake();
    chk("b2b_end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
